// File: rtl/phase_shift_gen.sv
// phase_shift_gen
// ---------------
// Two-channel square-wave generator. sig_ref has a programmable period.
// sig_shift is a copy of sig_ref that lags it by a programmable number of clk
// cycles. A new config offered while running goes into a shadow register. It
// takes effect only at the end of the current period, so neither output
// glitches when the config changes.
//
// Handshake: a config transfers on any cycle where cfg_valid & cfg_ready is
// high. The source holds cfg_period/cfg_phase stable while cfg_valid is high
// and cfg_ready is low. cfg_ready depends only on state, never on cfg_valid.
//
// Optional feature: define PHASE_GEN_MARKER_EN to add the ref_fall output, a
// one-cycle pulse aligned with the first low cycle of sig_ref.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   en                 run enable (low: outputs 0, counter held at 0)
//   cfg_valid/ready    config handshake
//   cfg_period         period in clk cycles (valid when >= 2)
//   cfg_phase          lag of sig_shift in clk cycles (valid when < period)
//   cfg_err            one-cycle pulse after an invalid config is accepted
//   running            registered: en high and an active config exists
//   sig_ref, sig_shift registered square waves
//   ref_fall           (PHASE_GEN_MARKER_EN only) falling-edge marker
module phase_shift_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             running,
  output logic             sig_ref,
  output logic             sig_shift
`ifdef PHASE_GEN_MARKER_EN
  ,
  output logic             ref_fall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_phase;
  logic [CNT_W-1:0] shd_period;
  logic [CNT_W-1:0] shd_phase;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             cfg_ok;
  logic             active;
  logic             wrap;
  logic             load_new;
  logic             load_shadow;
  logic             apply_shadow;
  logic [CNT_W-1:0] half;
  logic [CNT_W:0]   pcnt;

  assign accept = cfg_valid & cfg_ready;
  assign cfg_ok = (cfg_period >= CNT_W'(2)) && (cfg_phase < cfg_period);
  assign wrap   = (cnt == (act_period - CNT_W'(1)));
  assign half   = act_period >> 1;

  // Position within the lagged waveform. The calculation is done one bit
  // wider, so cnt + period - phase cannot overflow for large periods.
  assign pcnt = ({1'b0, cnt} >= {1'b0, act_phase})
              ? ({1'b0, cnt} - {1'b0, act_phase})
              : ({1'b0, cnt} + {1'b0, act_period} - {1'b0, act_phase});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. An invalid config still completes the handshake, but it
  // leaves state, the active config and the counter unchanged.
  always_comb begin
    state_nxt    = state;
    load_new     = 1'b0;
    load_shadow  = 1'b0;
    apply_shadow = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cfg_ok) begin
          state_nxt = ST_RUN;
          load_new  = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && cfg_ok) begin
          state_nxt   = ST_PEND;
          load_shadow = 1'b1;
        end
      end
      ST_PEND: begin
        // Swap at the period boundary. If en is low the outputs are already
        // quiet, so the swap can happen at once.
        if (!en || wrap) begin
          state_nxt    = ST_RUN;
          apply_shadow = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cfg_ready = 1'b1;
    active    = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        active    = 1'b0;
      end
      ST_RUN: begin
        cfg_ready = 1'b1;
        active    = 1'b1;
      end
      ST_PEND: begin
        cfg_ready = 1'b0;
        active    = 1'b1;
      end
      default: begin
        cfg_ready = 1'b1;
        active    = 1'b0;
      end
    endcase
  end

  // Config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period <= '0;
      act_phase  <= '0;
      shd_period <= '0;
      shd_phase  <= '0;
    end else begin
      if (load_new) begin
        act_period <= cfg_period;
        act_phase  <= cfg_phase;
      end else if (apply_shadow) begin
        act_period <= shd_period;
        act_phase  <= shd_phase;
      end
      if (load_shadow) begin
        shd_period <= cfg_period;
        shd_phase  <= cfg_phase;
      end
    end
  end

  // Period counter. A shadow swap only happens at wrap or while en is low,
  // and both of those already return the counter to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (active && en && !wrap) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err   <= 1'b0;
      running   <= 1'b0;
      sig_ref   <= 1'b0;
      sig_shift <= 1'b0;
    end else begin
      cfg_err   <= accept & ~cfg_ok;
      running   <= en & active;
      sig_ref   <= en & active & (cnt < half);
      sig_shift <= en & active & (pcnt < {1'b0, half});
    end
  end

`ifdef PHASE_GEN_MARKER_EN
  // sig_ref is high for cnt 0 .. half-1, so its first low cycle follows the
  // edge at which cnt == half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_fall <= 1'b0;
    end else begin
      ref_fall <= en & active & (cnt == half);
    end
  end
`endif

endmodule

// File: tb/tb_phase_shift_gen.sv
// Self-checking bench for phase_shift_gen. A behavioural model predicts the
// output vector for every cycle: {cfg_ready, cfg_err, running, sig_ref,
// sig_shift[, ref_fall]}. The model computes waveform levels with modular
// arithmetic on a cycle index.
module tb_phase_shift_gen;

  localparam int CNT_W = 16;
`ifdef PHASE_GEN_MARKER_EN
  localparam int VW = 6;
`else
  localparam int VW = 5;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_phase = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             running;
  logic             sig_ref;
  logic             sig_shift;
`ifdef PHASE_GEN_MARKER_EN
  logic             ref_fall;
`endif

  always #5 clk = ~clk;

  phase_shift_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_phase  (cfg_phase),
    .cfg_err    (cfg_err),
    .running    (running),
    .sig_ref    (sig_ref),
    .sig_shift  (sig_shift)
`ifdef PHASE_GEN_MARKER_EN
    ,
    .ref_fall   (ref_fall)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  string         tag = "reset";
  logic [VW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  bit m_have;   // an active config exists
  bit m_pend;   // a shadow config is waiting
  int m_period, m_phase, m_sp, m_sph, m_cnt;

  function automatic logic [VW-1:0] got_vec();
`ifdef PHASE_GEN_MARKER_EN
    return {cfg_ready, cfg_err, running, sig_ref, sig_shift, ref_fall};
`else
    return {cfg_ready, cfg_err, running, sig_ref, sig_shift};
`endif
  endfunction

  function automatic logic [VW-1:0] reset_vec();
    logic [VW-1:0] v;
    v = '0;
    v[VW-1] = 1'b1;  // cfg_ready
    return v;
  endfunction

  task automatic model_reset();
    m_have = 0; m_pend = 0; m_period = 0; m_phase = 0;
    m_sp = 0; m_sph = 0; m_cnt = 0;
  endtask

  task automatic compare(input logic [VW-1:0] exp);
    logic [VW-1:0] got;
    got = got_vec();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock. The expected vector is predicted from the inputs and
  // model state before the edge, then compared #1 after the edge.
  task automatic tick();
    bit acc, ok, wrap, e_err, e_run, e_ref, e_sh, e_fall;
    logic [VW-1:0] e;
    if (!rst_n) begin
      model_reset();
      e = reset_vec();
    end else begin
      acc    = cfg_valid && !m_pend;
      ok     = (int'(cfg_period) >= 2) && (int'(cfg_phase) < int'(cfg_period));
      e_err  = acc && !ok;
      e_run  = en && m_have;
      e_ref  = e_run && (m_cnt < m_period / 2);
      e_sh   = e_run && (((m_cnt - m_phase + m_period) % m_period) < m_period / 2);
      e_fall = e_run && (m_cnt == m_period / 2);
      wrap   = e_run && (m_cnt == m_period - 1);
      if (!m_have) begin
        if (acc && ok) begin
          m_have = 1; m_period = int'(cfg_period); m_phase = int'(cfg_phase);
        end
        m_cnt = 0;
      end else if (m_pend && (!en || wrap)) begin
        m_period = m_sp; m_phase = m_sph; m_pend = 0; m_cnt = 0;
      end else begin
        m_cnt = (en && !wrap) ? m_cnt + 1 : 0;
        if (acc && ok) begin
          m_sp = int'(cfg_period); m_sph = int'(cfg_phase); m_pend = 1;
        end
      end
`ifdef PHASE_GEN_MARKER_EN
      e = {!m_pend, e_err, e_run, e_ref, e_sh, e_fall};
`else
      e = {!m_pend, e_err, e_run, e_ref, e_sh};
`endif
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    compare(exp_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- driver ----------------
  // Holds cfg_valid until the handshake completes, with a bounded wait.
  task automatic offer(input int p, input int ph);
    bit done;
    done = 0;
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_phase  = CNT_W'(ph);
    for (int i = 0; i < 300 && !done; i++) begin
      done = !m_pend;
      tick();
    end
    cfg_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $error("FAIL %s offer_timeout observed=no_accept expected=accept", tag);
    end
  endtask

  task automatic wait_cnt(input int target);
    int i;
    i = 0;
    while ((m_pend || m_cnt != target) && i < 200) begin
      tick(); i++;
    end
    tests++;
    assert (i < 200) else begin
      fails++;
      $error("FAIL %s wait_cnt observed=timeout expected=cnt_%0d", tag, target);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();

    // Reset values
    tag = "reset";
    #1;
    compare(reset_vec());
    run(2);
    #2 rst_n = 1'b1;
    en = 1'b1;
    tag = "idle";
    run(3);

    // Basic: period 8, phase 2
    tag = "basic";
    offer(8, 2);
    tick();
    tests++;
    assert (sig_ref === 1'b1 && sig_shift === 1'b0) else begin
      fails++;
      $error("FAIL start_latency observed=%b%b expected=10", sig_ref, sig_shift);
    end
    run(30);

    // Rejected configs
    tag = "reject_p1";
    offer(1, 0);
    run(4);
    tag = "reject_p10ph10";
    offer(10, 10);
    run(4);

    // Mid-run change
    tag = "midrun";
    offer(10, 3);
    wait_cnt(4);
    offer(6, 1);
    tests++;
    assert (cfg_ready === 1'b0) else begin
      fails++;
      $error("FAIL midrun_ready observed=%b expected=0", cfg_ready);
    end
    run(30);

    // Odd period, extreme lag
    tag = "odd";
    offer(7, 6);
    run(150);

    // Phase 0
    tag = "phase0";
    offer(5, 0);
    run(20);

    // Enable drop mid-period and restart
    tag = "enable";
    run(2);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(20);

    // Reset asserted while PEND
    tag = "reset_pend";
    offer(9, 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare(reset_vec());
    run(2);
    #2 rst_n = 1'b1;
    run(5);

    // Random stimulus
    tag = "random";
    offer(12, 5);
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        en = ~en;
        tick();
      end else if (r < 6) begin
        offer(int'($urandom_range(0, 24)), int'($urandom_range(0, 24)));
      end else begin
        tick();
      end
    end

    // Marker: period 8, then silence with en low
    tag = "marker";
    en = 1'b1;
    offer(8, 3);
    run(40);
    en = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_shift_gen.md
# phase_shift_gen

- Programmable two-channel square-wave generator on the system clock: a reference output `sig_ref` and a delayed copy `sig_shift`, lagging by a configured number of clock cycles.
- Drives the stimulus end of the phase-measurement path. Supplies known-phase signal pairs to the sampling/edge-detect front end for calibration and self-test.
- Resolution is one `clk` period (5 ns at 200 MHz).

## Interface
- `CNT_W`, 16: width of the period and phase registers and counters.
- `clk`  in  1  system clock (200 MHz).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  run enable; low forces outputs low and holds the counter at 0.
- `cfg_valid`  in  1  config offer.
- `cfg_ready`  out  1  config can be accepted; transfer when `cfg_valid & cfg_ready`.
- `cfg_period`  in  CNT_W  output period in clk cycles.
- `cfg_phase`  in  CNT_W  lag of `sig_shift` behind `sig_ref`, in clk cycles.
- `cfg_err`  out  1  one-cycle pulse: the accepted config was rejected.
- `running`  out  1  high when `en` is high and an active config exists.
- `sig_ref`  out  1  reference square wave.
- `sig_shift`  out  1  phase-shifted square wave.

## Operation
- **States:** IDLE (no active config), RUN, PEND (RUN with a shadow config waiting).
- **Ready:** `cfg_ready` = 1 in IDLE and RUN, 0 in PEND.
- **Validation:** a config is valid iff `cfg_period >= 2` and `cfg_phase < cfg_period`.
  - An invalid config is still accepted: handshake completes and `cfg_err` pulses on the next cycle.
  - State, active config and counter are unchanged.
- **IDLE + valid accept:** load the active config, `cnt` = 0, go to RUN.
- **RUN + valid accept:** latch into the shadow, go to PEND.
- **PEND:** on the cycle where `cnt == period-1` (wrap), load the shadow into the active config, `cnt` = 0, go to RUN. This keeps changes glitch-free.
- **Accept on the wrap cycle (RUN):** the config goes to PEND and applies at the *next* wrap.
- **Counter:** `cnt` counts 0 .. `period-1` and wraps to 0 while `en` = 1 in RUN/PEND.
- **Derived values:**
  - `half` = `period >> 1` (odd periods give low time longer by one cycle).
  - `pcnt` = `cnt >= phase ? cnt - phase : cnt + period - phase`, computed at CNT_W+1 bits with no overflow.
- **Enable low:** `cnt` = 0, outputs 0. Any PEND shadow is applied immediately (PEND to RUN). The active config is retained.
- **Reset:** all state cleared to IDLE. Any in-flight config is lost.

## Timing
- **Reset values:** `cfg_ready`=1, `cfg_err`=0, `running`=0, `sig_ref`=0, `sig_shift`=0, state IDLE, `cnt`=0.
- **Registered outputs:**
  - `sig_ref(t+1) = en & active & (cnt(t) < half)`.
  - `sig_shift(t+1) = en & active & (pcnt(t) < half)`.
- **Start latency:** `sig_ref` rises 2 cycles after the IDLE accept edge (accept cycle, `cnt`=0 cycle, then output).
- **Lag:** `sig_shift` rising edges trail `sig_ref` rising edges by exactly `phase` cycles, every period, including the first period after a config change.
- **First period after accept:** `sig_shift` is already in steady state (`pcnt` is used from `cnt`=0, so it is high initially if `period-phase < half`).
- **`running`:** registered, 1-cycle latency from `en` or state change.
- **`en` rising:** `cnt` starts from 0 on the first cycle `en`=1.
- **Phase 0:** `sig_shift` is identical to `sig_ref`.

## Configuration
- **`PHASE_GEN_MARKER_EN` defined:** adds output `ref_fall` (1 bit, reset 0). It is a one-cycle registered pulse coincident with the first low cycle of `sig_ref`, i.e. the same falling-edge strobe the receive-side edge detector regenerates. It is used as a loopback check reference.
- **Undefined:** the port and its logic are absent.

## Test plan
- **Basic:** period 8, phase 2, `en`=1.
  - `sig_ref` = 4 high / 4 low, starting 2 cycles after the accept.
  - `sig_shift` rises exactly 2 cycles after each `sig_ref` rise.
  - `running`=1.
- **Rejected configs:** each is accepted with `cfg_ready`=1, `cfg_err` pulses once, outputs unchanged.
  - Period 1, phase 0.
  - Period 10, phase 10.
- **Mid-run change:** running at period 10 / phase 3, offer period 6 / phase 1 at `cnt`=4.
  - `cfg_ready` drops.
  - The current 10-cycle period completes intact.
  - The next period is 6 cycles with a lag of 1.
  - `cfg_ready` returns.
- **Odd period and extreme lag:** period 7, phase 6.
  - `sig_ref` = 3 high / 4 low.
  - `sig_shift` lags by 6 (equivalently leads by 1).
  - No glitches over 20 periods.
- **Enable and reset:**
  - Drop `en` mid-period: outputs 0 after 1 cycle. Raise `en`: restart from `cnt`=0 with the retained config.
  - Assert `rst_n` low mid-PEND: all outputs return to reset values, IDLE, shadow discarded.
- **Marker (`PHASE_GEN_MARKER_EN`):** period 8.
  - `ref_fall` pulses once per 8 cycles, aligned with the first low cycle of `sig_ref`.
  - `ref_fall` stays silent while `en`=0.
